// File: rtl/non_max_suppress.sv
// Streaming 3x3 non-maximum suppression for a Canny edge pipeline.
// Keeps the two previous columns; the incoming column closes the window.
module non_max_suppress #(
    parameter int WIDTH = 5
) (
    input  logic             clk_p_i,
    input  logic             reset_p_i,
    input  logic [1:0]       angle_i,
    input  logic [WIDTH-1:0] pixel_in0_i,
    input  logic [WIDTH-1:0] pixel_in1_i,
    input  logic [WIDTH-1:0] pixel_in2_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] pixel_out_o,
    output logic             readable_o
);

    logic [WIDTH-1:0] col_a_top_r;
    logic [WIDTH-1:0] col_a_mid_r;
    logic [WIDTH-1:0] col_a_bot_r;
    logic [WIDTH-1:0] col_b_top_r;
    logic [WIDTH-1:0] col_b_mid_r;
    logic [WIDTH-1:0] col_b_bot_r;
    logic [1:0]       angle_r;
    logic [1:0]       fill_r;

    logic [WIDTH-1:0] nbr_1_s;
    logic [WIDTH-1:0] nbr_2_s;
    logic [WIDTH-1:0] result_s;
    logic             window_full_s;

    assign window_full_s = (fill_r == 2'd2);

    // Column shift register, direction tracking and fill count
    always_ff @(posedge clk_p_i or negedge reset_p_i) begin
        if (!reset_p_i) begin
            col_a_top_r <= {WIDTH{1'b0}};
            col_a_mid_r <= {WIDTH{1'b0}};
            col_a_bot_r <= {WIDTH{1'b0}};
            col_b_top_r <= {WIDTH{1'b0}};
            col_b_mid_r <= {WIDTH{1'b0}};
            col_b_bot_r <= {WIDTH{1'b0}};
            angle_r     <= 2'd0;
            fill_r      <= 2'd0;
        end else begin
            col_a_top_r <= col_b_top_r;
            col_a_mid_r <= col_b_mid_r;
            col_a_bot_r <= col_b_bot_r;
            col_b_top_r <= pixel_in0_i;
            col_b_mid_r <= pixel_in1_i;
            col_b_bot_r <= pixel_in2_i;
            angle_r     <= angle_i;
            if (window_full_s) begin
                fill_r <= fill_r;
            end else begin
                fill_r <= fill_r + 2'd1;
            end
        end
    end

    // Pick the two neighbours lying along the gradient direction of the centre
    always_comb begin
        nbr_1_s = {WIDTH{1'b0}};
        nbr_2_s = {WIDTH{1'b0}};
        case (angle_r)
            2'd0: begin
                nbr_1_s = col_a_mid_r;
                nbr_2_s = pixel_in1_i;
            end
            2'd1: begin
                nbr_1_s = col_a_bot_r;
                nbr_2_s = pixel_in0_i;
            end
            2'd2: begin
                nbr_1_s = col_b_top_r;
                nbr_2_s = col_b_bot_r;
            end
            2'd3: begin
                nbr_1_s = col_a_top_r;
                nbr_2_s = pixel_in2_i;
            end
            default: begin
                nbr_1_s = {WIDTH{1'b0}};
                nbr_2_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Ties keep the centre so plateaus along the edge are not thinned away
    always_comb begin
        result_s = {WIDTH{1'b0}};
        if ((col_b_mid_r >= nbr_1_s) && (col_b_mid_r >= nbr_2_s)) begin
            result_s = col_b_mid_r;
        end else begin
            result_s = {WIDTH{1'b0}};
        end
    end

    // Registered outputs
    always_ff @(posedge clk_p_i or negedge reset_p_i) begin
        if (!reset_p_i) begin
            pixel_out_o <= {WIDTH{1'b0}};
            readable_o  <= 1'b0;
        end else begin
            pixel_out_o <= result_s;
            readable_o  <= enable_i & window_full_s;
        end
    end

endmodule

// File: tb/tb_non_max_suppress.sv
// Directed and random-stream checks for non_max_suppress.
module tb_non_max_suppress;

    logic       clk_p_i;
    logic       reset_p_i;
    logic [1:0] angle_i;
    logic [4:0] pixel_in0_i;
    logic [4:0] pixel_in1_i;
    logic [4:0] pixel_in2_i;
    logic       enable_i;
    logic [4:0] pixel_out_o;
    logic       readable_o;

    int checks;
    int errors;
    int n_out;

    logic [4:0] tp [0:101];
    logic [4:0] md [0:101];
    logic [4:0] bt [0:101];
    logic [1:0] an [0:101];

    non_max_suppress #(.WIDTH(5)) dut (
        .clk_p_i    (clk_p_i),
        .reset_p_i  (reset_p_i),
        .angle_i    (angle_i),
        .pixel_in0_i(pixel_in0_i),
        .pixel_in1_i(pixel_in1_i),
        .pixel_in2_i(pixel_in2_i),
        .enable_i   (enable_i),
        .pixel_out_o(pixel_out_o),
        .readable_o (readable_o)
    );

    initial clk_p_i = 1'b0;
    always #5 clk_p_i = ~clk_p_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic step(input logic [4:0] t, input logic [4:0] m, input logic [4:0] b,
                        input logic [1:0] a, input logic en);
        pixel_in0_i = t;
        pixel_in1_i = m;
        pixel_in2_i = b;
        angle_i     = a;
        enable_i    = en;
        @(posedge clk_p_i);
        #1;
    endtask

    function automatic logic [4:0] nms_ref(input int k);
        logic [4:0] n1;
        logic [4:0] n2;
        case (an[k])
            2'd0: begin n1 = md[k-1]; n2 = md[k+1]; end
            2'd1: begin n1 = bt[k-1]; n2 = tp[k+1]; end
            2'd2: begin n1 = tp[k];   n2 = bt[k];   end
            default: begin n1 = tp[k-1]; n2 = bt[k+1]; end
        endcase
        return ((md[k] >= n1) && (md[k] >= n2)) ? md[k] : 5'd0;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        n_out  = 0;
        reset_p_i   = 1'b0;
        angle_i     = 2'd0;
        pixel_in0_i = 5'd0;
        pixel_in1_i = 5'd0;
        pixel_in2_i = 5'd0;
        enable_i    = 1'b0;
        #12;
        check("reset_pixel", {27'd0, pixel_out_o}, 32'd0);
        check("reset_readable", {31'd0, readable_o}, 32'd0);
        reset_p_i = 1'b1;
        @(posedge clk_p_i);
        #1;

        // Priming columns then first window
        step(5'd0, 5'd0, 5'd0, 2'd0, 1'b0);
        step(5'd0, 5'd5, 5'd0, 2'd0, 1'b0);
        check("prime_not_readable", {31'd0, readable_o}, 32'd0);
        step(5'd0, 5'd0, 5'd0, 2'd0, 1'b1);
        check("prime_readable", {31'd0, readable_o}, 32'd1);
        check("prime_pixel", {27'd0, pixel_out_o}, 32'd5);

        // Horizontal suppression and tie
        step(5'd0, 5'd3, 5'd0, 2'd2, 1'b1);
        step(5'd0, 5'd4, 5'd0, 2'd0, 1'b1);
        step(5'd0, 5'd9, 5'd0, 2'd3, 1'b1);
        check("ang0_suppress", {27'd0, pixel_out_o}, 32'd0);
        check("ang0_readable", {31'd0, readable_o}, 32'd1);
        step(5'd0, 5'd3, 5'd0, 2'd1, 1'b1);
        step(5'd0, 5'd4, 5'd0, 2'd0, 1'b1);
        step(5'd0, 5'd4, 5'd0, 2'd1, 1'b1);
        check("ang0_tie", {27'd0, pixel_out_o}, 32'd4);

        // Diagonals
        step(5'd0, 5'd0, 5'd12, 2'd0, 1'b1);
        step(5'd0, 5'd10, 5'd0, 2'd1, 1'b1);
        step(5'd1, 5'd0, 5'd0, 2'd0, 1'b1);
        check("ang1_suppress", {27'd0, pixel_out_o}, 32'd0);
        step(5'd2, 5'd0, 5'd12, 2'd0, 1'b1);
        step(5'd0, 5'd10, 5'd0, 2'd3, 1'b1);
        step(5'd1, 5'd0, 5'd3, 2'd0, 1'b1);
        check("ang3_keep", {27'd0, pixel_out_o}, 32'd10);
        step(5'd11, 5'd0, 5'd0, 2'd0, 1'b1);
        step(5'd0, 5'd10, 5'd0, 2'd3, 1'b1);
        step(5'd0, 5'd0, 5'd3, 2'd0, 1'b1);
        check("ang3_suppress", {27'd0, pixel_out_o}, 32'd0);
        step(5'd0, 5'd0, 5'd10, 2'd0, 1'b1);
        step(5'd0, 5'd10, 5'd0, 2'd1, 1'b1);
        step(5'd1, 5'd0, 5'd0, 2'd0, 1'b1);
        check("ang1_tie", {27'd0, pixel_out_o}, 32'd10);

        // Vertical and full-scale
        step(5'd31, 5'd31, 5'd31, 2'd0, 1'b1);
        step(5'd7, 5'd20, 5'd19, 2'd2, 1'b1);
        step(5'd31, 5'd31, 5'd31, 2'd0, 1'b1);
        check("ang2_keep", {27'd0, pixel_out_o}, 32'd20);
        step(5'd31, 5'd31, 5'd31, 2'd0, 1'b1);
        step(5'd21, 5'd20, 5'd0, 2'd2, 1'b1);
        step(5'd31, 5'd31, 5'd31, 2'd0, 1'b1);
        check("ang2_suppress", {27'd0, pixel_out_o}, 32'd0);
        step(5'd31, 5'd31, 5'd31, 2'd0, 1'b1);
        step(5'd31, 5'd31, 5'd31, 2'd0, 1'b1);
        check("max_tie", {27'd0, pixel_out_o}, 32'd31);

        // Enable drop
        step(5'd0, 5'd0, 5'd0, 2'd0, 1'b0);
        check("enable_drop", {31'd0, readable_o}, 32'd0);

        // Random stream of 102 columns, enable from the third column
        for (int j = 0; j < 102; j++) begin
            tp[j] = 5'($urandom_range(31, 0));
            md[j] = 5'($urandom_range(31, 0));
            bt[j] = 5'($urandom_range(31, 0));
            an[j] = 2'($urandom_range(3, 0));
        end
        for (int j = 0; j < 102; j++) begin
            step(tp[j], md[j], bt[j], an[j], (j >= 2));
            if (readable_o === 1'b1) n_out++;
            if (j >= 2) begin
                check("stream_readable", {31'd0, readable_o}, 32'd1);
                check("stream_pixel", {27'd0, pixel_out_o}, {27'd0, nms_ref(j - 1)});
            end else begin
                check("stream_idle", {31'd0, readable_o}, 32'd0);
            end
        end
        step(5'd0, 5'd0, 5'd0, 2'd0, 1'b0);
        if (readable_o === 1'b1) n_out++;
        check("stream_count", n_out, 32'd100);

        // Reset mid-stream with enable held high
        step(5'd0, 5'd1, 5'd0, 2'd0, 1'b1);
        step(5'd0, 5'd9, 5'd0, 2'd0, 1'b1);
        step(5'd0, 5'd2, 5'd0, 2'd0, 1'b1);
        check("pre_reset_pixel", {27'd0, pixel_out_o}, 32'd9);
        reset_p_i = 1'b0;
        #1;
        check("midreset_pixel", {27'd0, pixel_out_o}, 32'd0);
        check("midreset_readable", {31'd0, readable_o}, 32'd0);
        #1;
        reset_p_i = 1'b1;
        step(5'd0, 5'd0, 5'd0, 2'd0, 1'b1);
        check("post_reset_col1", {31'd0, readable_o}, 32'd0);
        step(5'd0, 5'd6, 5'd0, 2'd0, 1'b1);
        check("post_reset_col2", {31'd0, readable_o}, 32'd0);
        step(5'd0, 5'd1, 5'd0, 2'd0, 1'b1);
        check("post_reset_col3", {31'd0, readable_o}, 32'd1);
        check("post_reset_pixel", {27'd0, pixel_out_o}, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
